// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, reset PC, NOP encoding, fetch FSM encoding and queue entry type.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small {pc,instr} FIFO with flush; the head output holds its last value when empty.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         valid,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  fetch_entry_t hold;
  logic [AW-1:0] rd, wr;
  assign valid = count != '0;
  assign head = valid ? mem[rd] : hold;
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= push_entry;
  // hold tracks the live head so decode sees a stable word once the queue drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      hold <= '{pc: '0, instr: NOP};
    end else begin
      if (valid) hold <= mem[rd];
      if (flush) begin
        rd <= '0;
        wr <= '0;
        count <= '0;
      end else begin
        if (push) wr <= wr + 1'b1;
        if (pop) rd <= rd + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC register, credit-limited IMEM fetch FSM with redirect/drop handling,
// feeding {instr, pc} to decode through fetch_queue.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_plus1,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [1:0] state, state_nx;
  logic [31:0] fetch_pc;
  logic [CW-1:0] count, cnt_after;
  logic push, pop, credit;
  fetch_entry_t head;
  assign mem_req = state == S_REQ;
  assign mem_addr = fetch_pc;
  assign push = state == S_WAIT && mem_rvalid && !redirect;
  assign pop = instr_valid && instr_ready;
  // credit is judged on the occupancy after this cycle's push/pop with nothing in flight
  assign cnt_after = count + CW'(push) - CW'(pop);
  assign credit = cnt_after < CW'(QDEPTH);
  assign instr = head.instr;
  assign instr_pc = head.pc;
  assign pc_plus1 = head.pc + 32'd1;
  always_comb begin
    state_nx = state;
    if (redirect)
      state_nx = ((state == S_REQ && mem_gnt) ||
                  ((state == S_WAIT || state == S_DROP) && !mem_rvalid)) ? S_DROP : S_REQ;
    else
      unique case (state)
        S_IDLE:  state_nx = credit ? S_REQ : S_IDLE;
        S_REQ:   state_nx = mem_gnt ? S_WAIT : S_REQ;
        S_WAIT:  state_nx = mem_rvalid ? (credit ? S_REQ : S_IDLE) : S_WAIT;
        default: state_nx = mem_rvalid ? S_REQ : S_DROP;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nx;
      if (redirect) fetch_pc <= redirect_pc;
      else if (state == S_REQ && mem_gnt) fetch_pc <= fetch_pc + 32'd1;
    end
  // fetch_pc already advanced at grant, so the returning word belongs to fetch_pc-1
  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_entry('{pc: fetch_pc - 32'd1, instr: mem_rdata}),
    .pop(pop),
    .flush(redirect),
    .valid(instr_valid),
    .head(head),
    .count(count)
  );
endmodule
